// File: rtl/bios_rom_pkg.sv
// Shared constants for the DMG-01 boot ROM: size and the golden 256-byte image.
package bios_rom_pkg;

    localparam int unsigned BOOT_ROM_SIZE   = 256;
    localparam int unsigned BOOT_ROM_ADDR_W = 8;
    localparam int unsigned BOOT_ROM_DATA_W = 8;

    // Byte-exact DMG-01 boot ROM, offset 0x00 first, 16 bytes per row.
    localparam logic [BOOT_ROM_DATA_W-1:0] BOOT_ROM_IMAGE [BOOT_ROM_SIZE] = '{
        8'h31, 8'hFE, 8'hFF, 8'hAF, 8'h21, 8'hFF, 8'h9F, 8'h32, 8'hCB, 8'h7C, 8'h20, 8'hFB, 8'h21, 8'h26, 8'hFF, 8'h0E,
        8'h11, 8'h3E, 8'h80, 8'h32, 8'hE2, 8'h0C, 8'h3E, 8'hF3, 8'hE2, 8'h32, 8'h3E, 8'h77, 8'h77, 8'h3E, 8'hFC, 8'hE0,
        8'h47, 8'h11, 8'h04, 8'h01, 8'h21, 8'h10, 8'h80, 8'h1A, 8'hCD, 8'h95, 8'h00, 8'hCD, 8'h96, 8'h00, 8'h13, 8'h7B,
        8'hFE, 8'h34, 8'h20, 8'hF3, 8'h11, 8'hD8, 8'h00, 8'h06, 8'h08, 8'h1A, 8'h13, 8'h22, 8'h23, 8'h05, 8'h20, 8'hF9,
        8'h3E, 8'h19, 8'hEA, 8'h10, 8'h99, 8'h21, 8'h2F, 8'h99, 8'h0E, 8'h0C, 8'h3D, 8'h28, 8'h08, 8'h32, 8'h0D, 8'h20,
        8'hF9, 8'h2E, 8'h0F, 8'h18, 8'hF3, 8'h67, 8'h3E, 8'h64, 8'h57, 8'hE0, 8'h42, 8'h3E, 8'h91, 8'hE0, 8'h40, 8'h04,
        8'h1E, 8'h02, 8'h0E, 8'h0C, 8'hF0, 8'h44, 8'hFE, 8'h90, 8'h20, 8'hFA, 8'h0D, 8'h20, 8'hF7, 8'h1D, 8'h20, 8'hF2,
        8'h0E, 8'h13, 8'h24, 8'h7C, 8'h1E, 8'h83, 8'hFE, 8'h62, 8'h28, 8'h06, 8'h1E, 8'hC1, 8'hFE, 8'h64, 8'h20, 8'h06,
        8'h7B, 8'hE2, 8'h0C, 8'h3E, 8'h87, 8'hE2, 8'hF0, 8'h42, 8'h90, 8'hE0, 8'h42, 8'h15, 8'h20, 8'hD2, 8'h05, 8'h20,
        8'h4F, 8'h16, 8'h20, 8'h18, 8'hCB, 8'h4F, 8'h06, 8'h04, 8'hC5, 8'hCB, 8'h11, 8'h17, 8'hC1, 8'hCB, 8'h11, 8'h17,
        8'h05, 8'h20, 8'hF5, 8'h22, 8'h23, 8'h22, 8'h23, 8'hC9, 8'hCE, 8'hED, 8'h66, 8'h66, 8'hCC, 8'h0D, 8'h00, 8'h0B,
        8'h03, 8'h73, 8'h00, 8'h83, 8'h00, 8'h0C, 8'h00, 8'h0D, 8'h00, 8'h08, 8'h11, 8'h1F, 8'h88, 8'h89, 8'h00, 8'h0E,
        8'hDC, 8'hCC, 8'h6E, 8'hE6, 8'hDD, 8'hDD, 8'hD9, 8'h99, 8'hBB, 8'hBB, 8'h67, 8'h63, 8'h6E, 8'h0E, 8'hEC, 8'hCC,
        8'hDD, 8'hDC, 8'h99, 8'h9F, 8'hBB, 8'hB9, 8'h33, 8'h3E, 8'h3C, 8'h42, 8'hB9, 8'hA5, 8'hB9, 8'hA5, 8'h42, 8'h3C,
        8'h21, 8'h04, 8'h01, 8'h11, 8'hA8, 8'h00, 8'h1A, 8'h13, 8'hBE, 8'h20, 8'hFE, 8'h23, 8'h7D, 8'hFE, 8'h34, 8'h20,
        8'hF5, 8'h06, 8'h19, 8'h78, 8'h86, 8'h23, 8'h05, 8'h20, 8'hFB, 8'h86, 8'h20, 8'hFE, 8'h3E, 8'h01, 8'hE0, 8'h50
    };

    // Table lookup used by the ROM decode; every 8-bit offset is a valid entry.
    function automatic logic [BOOT_ROM_DATA_W-1:0] boot_rom_byte(input logic [BOOT_ROM_ADDR_W-1:0] addr);
        return BOOT_ROM_IMAGE[addr];
    endfunction

endpackage

// File: rtl/bios_rom.sv
// DMG-01 boot ROM: combinational table decode followed by one output register.
module bios_rom
    import bios_rom_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              iClock,
    input  logic              iReset,
    input  logic [ADDR_W-1:0] iAddr,
    output logic [DATA_W-1:0] oData
);

    logic [BOOT_ROM_ADDR_W-1:0] rom_addr_c;
    logic [DATA_W-1:0]          data_d;
    logic [DATA_W-1:0]          data_q;

    // Decode the current address into the next output byte.
    always_comb begin
        rom_addr_c = BOOT_ROM_ADDR_W'(iAddr);
        data_d     = DATA_W'(boot_rom_byte(rom_addr_c));
    end

    // Output register; reset clears it immediately so no stale byte survives.
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign oData = data_q;

endmodule

// File: tb/tb_bios_rom.sv
// Directed bench for bios_rom: reset behaviour, latency, full sweep, boundaries.
module tb_bios_rom;
    import bios_rom_pkg::*;

    logic       iClock;
    logic       iReset;
    logic [7:0] iAddr;
    logic [7:0] oData;

    int errors;
    int checks;

    bios_rom #(.ADDR_W(8), .DATA_W(8)) dut (
        .iClock (iClock),
        .iReset (iReset),
        .iAddr  (iAddr),
        .oData  (oData)
    );

    initial iClock = 1'b0;
    always #5 iClock = ~iClock;

    // Present an address on the falling edge, sample one step after the next rising edge.
    task automatic read_cycle(input logic [7:0] addr);
        @(negedge iClock);
        iAddr = addr;
        @(posedge iClock);
        #1;
    endtask

    task automatic test_reset;
        iReset = 1'b0;
        iAddr  = 8'h05;
        #1;
        checks++;
        if (oData !== 8'h00) begin
            errors++;
            $display("FAIL reset_async: got %h expected 00", oData);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge iClock);
            #1;
            checks++;
            if (oData !== 8'h00) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got %h expected 00", i, oData);
            end
        end
    endtask

    task automatic test_first_reads;
        logic [7:0] addrs [3];
        logic [7:0] exp   [3];
        addrs = '{8'h00, 8'h01, 8'h02};
        exp   = '{8'h31, 8'hFE, 8'hFF};
        @(negedge iClock);
        iReset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            read_cycle(addrs[i]);
            checks++;
            if (oData !== exp[i]) begin
                errors++;
                $display("FAIL first_read addr=%h: got %h expected %h", addrs[i], oData, exp[i]);
            end
        end
    endtask

    // Hand-typed checkpoint bytes, independent of the package image.
    task automatic test_checkpoints;
        logic [7:0] addrs [16];
        logic [7:0] exp   [16];
        addrs = '{8'h03, 8'h04, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0B, 8'h0C,
                  8'h0E, 8'hA9, 8'hAA, 8'hAD, 8'hAF, 8'hFC, 8'hFD, 8'hFE};
        exp   = '{8'hAF, 8'h21, 8'h9F, 8'h32, 8'hCB, 8'h7C, 8'hFB, 8'h21,
                  8'hFF, 8'hED, 8'h66, 8'h0D, 8'h0B, 8'h3E, 8'h01, 8'hE0};
        for (int i = 0; i < 16; i++) begin
            read_cycle(addrs[i]);
            checks++;
            if (oData !== exp[i]) begin
                errors++;
                $display("FAIL checkpoint addr=%h: got %h expected %h", addrs[i], oData, exp[i]);
            end
        end
    endtask

    task automatic test_sweep;
        int bad;
        bad = 0;
        for (int a = 0; a < BOOT_ROM_SIZE; a++) begin
            read_cycle(8'(a));
            checks++;
            if (oData !== BOOT_ROM_IMAGE[a]) begin
                errors++;
                bad++;
                if (bad <= 8)
                    $display("FAIL sweep addr=%h: got %h expected %h", 8'(a), oData, BOOT_ROM_IMAGE[a]);
            end
        end
    endtask

    task automatic test_boundary;
        read_cycle(8'hFF);
        checks++;
        if (oData !== 8'h50) begin
            errors++;
            $display("FAIL boundary_ff: got %h expected 50", oData);
        end
        read_cycle(8'h00);
        checks++;
        if (oData !== 8'h31) begin
            errors++;
            $display("FAIL boundary_00: got %h expected 31", oData);
        end
    endtask

    task automatic test_midstream_reset;
        logic [7:0] a;
        for (int i = 0; i < 6; i++) begin
            a = 8'($urandom_range(0, 255));
            read_cycle(a);
            checks++;
            if (oData !== BOOT_ROM_IMAGE[a]) begin
                errors++;
                $display("FAIL random_read addr=%h: got %h expected %h", a, oData, BOOT_ROM_IMAGE[a]);
            end
        end
        // Drop reset between edges; the output must clear without a clock.
        #1;
        iReset = 1'b0;
        #1;
        checks++;
        if (oData !== 8'h00) begin
            errors++;
            $display("FAIL midstream_reset: got %h expected 00", oData);
        end
        @(posedge iClock);
        #1;
        checks++;
        if (oData !== 8'h00) begin
            errors++;
            $display("FAIL midstream_reset_hold: got %h expected 00", oData);
        end
        @(negedge iClock);
        iReset = 1'b1;
        iAddr  = 8'hA8;
        @(posedge iClock);
        #1;
        checks++;
        if (oData !== 8'hCE) begin
            errors++;
            $display("FAIL post_reset_read: got %h expected CE", oData);
        end
        read_cycle(8'hAB);
        checks++;
        if (oData !== 8'h66) begin
            errors++;
            $display("FAIL post_reset_next: got %h expected 66", oData);
        end
    endtask

    task automatic test_hold;
        for (int i = 0; i < 5; i++) begin
            read_cycle(8'h0A);
            checks++;
            if (oData !== 8'h20) begin
                errors++;
                $display("FAIL hold_edge[%0d]: got %h expected 20", i, oData);
            end
            #3;
            checks++;
            if (oData !== 8'h20) begin
                errors++;
                $display("FAIL hold_between[%0d]: got %h expected 20", i, oData);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        iReset = 1'b0;
        iAddr  = 8'h00;
        test_reset();
        test_first_reads();
        test_checkpoints();
        test_sweep();
        test_boundary();
        test_midstream_reset();
        test_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule

// File: doc/bios_rom.md
BIOS_ROM -- requirements
Module: bios_rom

Interface
REQ-001 Parameter ADDR_W, default 8, address width; ROM depth is 2**ADDR_W = 256 bytes.
REQ-002 Parameter DATA_W, default 8, data width in bits.
REQ-003 iClock  input  1  single clock; all state updates on its rising edge.
REQ-004 iReset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-005 iAddr  input  ADDR_W  byte address into the boot ROM (CPU address bits 7:0).
REQ-006 oData  output  DATA_W  registered ROM byte for the address sampled on the previous clock edge.

Function
REQ-007 The block SHALL be a read-only 256x8 memory holding the standard DMG-01 Game Boy boot ROM image, byte-exact at every offset 0x00-0xFF.
REQ-008 The block SHALL capture iAddr on each rising iClock edge and present ROM[iAddr] on oData after that same edge, giving exactly 1 cycle of read latency.
REQ-009 oData SHALL hold its value between edges and change only on a rising iClock edge or on reset assertion.
REQ-010 The block SHALL have no write port, and no input sequence SHALL alter ROM contents.
REQ-011 Every 8-bit address SHALL be valid, with no wrap-around, no out-of-range case and no X on oData for any known iAddr.
REQ-012 Back-to-back reads SHALL be supported every cycle, so address N on edge k gives ROM[N] after edge k for any sequence of N.
REQ-013 The following ROM contents are fixed checkpoints:
- 0x00-0x02 = 31 FE FF (LD SP,$FFFE)
- 0x03 = AF
- 0x04-0x06 = 21 FF 9F
- 0x07 = 32
- 0x08-0x09 = CB 7C
- 0x0A-0x0B = 20 FB
- 0x0C-0x0E = 21 26 FF
- 0xA8-0xAF = CE ED 66 66 CC 0D 00 0B (logo start)
- 0xFC-0xFF = 3E 01 E0 50 (LD A,$01; LDH ($50),A)
REQ-014 The block SHALL be implementable as synthesizable combinational decode (case table) or an initialized ROM array followed by one output register, with no latches.

Reset
REQ-015 While iReset = 0, oData SHALL be 8'h00, taking effect asynchronously without waiting for a clock edge.
REQ-016 On iReset deassertion, the first rising edge SHALL load ROM[iAddr], and no stale pre-reset value SHALL appear.
REQ-017 If reset is asserted mid-stream, oData SHALL go to 8'h00 immediately, and reads SHALL resume normally at the first edge after release.

Structure
REQ-018 A shared package SHALL hold BOOT_ROM_SIZE (256) and the 256-entry boot ROM image constant, so that bench and RTL share one golden image.
REQ-019 No sub-module is needed, and the block SHALL be a single flat module containing the decode table and the output register.
REQ-020 The enclosing MMU SHALL instantiate the block with instance name BIOS, connecting iClock, iReset, iAddr[7:0] and oData.

Verification
REQ-021 Assert iReset=0 with iAddr=0x05 and no clock edge -> oData=0x00 immediately; hold 3 edges -> oData stays 0x00.
REQ-022 Release reset, iAddr=0x00, one edge -> oData=0x31; then iAddr=0x01 -> 0xFE; iAddr=0x02 -> 0xFF, each 1 cycle after its address.
REQ-023 Sweep iAddr 0x00..0xFF, one per cycle -> oData matches the package image at each address delayed by 1 cycle, with zero mismatches and no X.
REQ-024 Boundary: iAddr=0xFF then 0x00 on consecutive cycles -> oData=0x50 then 0x31, with no wrap artifact.
REQ-025 Random addresses, with reset asserted asynchronously between edges -> oData=0x00 at once; after release, iAddr=0xA8 -> oData=0xCE one edge later.
REQ-026 Hold iAddr=0x0A constant for 5 edges -> oData=0x20 stable every cycle.
